id_ex_alu_issue: RTL and testbench
==================================

// Module: id_ex_alu_issue
// PURPOSE
// - ID->EX issue stage of the pipelined CPU: decodes a fetched MIPS word into ALU controls (aluc, shamt, operands) plus write-back/memory controls, and registers them for the EX-stage ALU.
// - Owns the valid/ready handshake between decode and execute, load-use bubble insertion and branch flush.
// PARAMETERS
// - XLEN     32  datapath width (operands, pc)
// - ALUC_W   4   width of aluc
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - in_valid   in   1       ID word valid
// - in_ready   out  1       stage can accept this cycle
// - instr      in   32      instruction word
// - rs_data    in   XLEN    register file value of rs
// - rt_data    in   XLEN    register file value of rt
// - flush      in   1       kill registered and incoming instruction (taken branch)
// - ex_ready   in   1       EX accepts current output
// - ex_valid   out  1       outputs below are valid
// - alu_a      out  XLEN    ALU operand a (rs_data)
// - alu_b      out  XLEN    ALU operand b (rt_data or extended imm)
// - alu_shamt  out  5       instr[10:6]
// - alu_aluc   out  ALUC_W  ALU op code
// - rf_w       out  1       write-back enable
// - rf_dst     out  5       destination register
// - mem_r      out  1       load
// - mem_w      out  1       store
// - branch     out  1       beq
// - illegal    out  1       unrecognised opcode/funct
// - stall_lu   out  1       load-use bubble being inserted this cycle
// BEHAVIOUR
// - Reset: all outputs 0; ex_valid=0; in_ready=1 once rst_n high.
// - aluc: 0000 addu/addiu/lw/sw; 0010 add/addi; 0001 sub/subu/beq/slt; 0011 and/andi; 0100 or/ori; 0110 xor/xori; 0101 nor; 1000 sll; 1110 movz; 1100 movn; illegal -> 0000, all enables 0, illegal=1.
// - alu_b: R-type rt_data; addi/addiu/lw/sw sign-extend imm16; andi/ori/xori zero-extend imm16.
// - rf_dst: rd for R-type, rt for I-type loads/ALU-imm; sw/beq/illegal rf_w=0; sll with instr==0 (nop) rf_w=0.
// - Handshake: in_ready = (!ex_valid | ex_ready) & !stall_lu; transfer on in_valid&in_ready; outputs load next edge, latency 1 cycle.
// - Hold: ex_valid & !ex_ready -> all outputs stable, no new word accepted.
// - Load-use: registered word is lw with rf_dst!=0 and incoming rs==rf_dst or (R-type/sw/beq and rt==rf_dst) -> stall_lu=1, in_ready=0, bubble (ex_valid=0) issued when EX advances; exactly one bubble per hazard.
// - Flush: highest priority; next edge ex_valid=0, incoming word dropped, stall_lu cleared; same-cycle in_valid ignored.
// - Async reset mid-operation clears pending word and any stall immediately.
// CONFIGURATION
// - MOVE_COND_EN defined: movz(funct 001010)->aluc 1110, movn(funct 001011)->aluc 1100, rf_w=1 (ALU not_move gates it in EX).
// - MOVE_COND_EN undefined: those functs decode as illegal (illegal=1, rf_w=0).
// STRUCTURE
// - alu_pkg: aluc constants, opcode/funct constants, XLEN default.
// - Sub-module alu_ctrl_dec: purely combinational instr->controls decoder; this module adds registers, handshake, hazard and flush logic.
// TESTING
// - Reset: rst_n=0 mid-transfer -> ex_valid=0, all outputs 0, in_ready=1 after release.
// - addi $2,$1,-1 (0x2022FFFF), rs_data=5 -> next cycle aluc=0010, alu_b=0xFFFFFFFF, rf_dst=2, rf_w=1.
// - ori $3,$0,0x8000 -> alu_b=0x00008000 (zero-extend), aluc=0100; sll $4,$5,3 -> aluc=1000, shamt=3.
// - lw $6,0($1) then add $7,$6,$6 -> stall_lu=1 one cycle, exactly one bubble, add issued next.
// - ex_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush with in_valid=1 -> ex_valid=0 next edge, word dropped.
// - movz 0x0043200A: with MOVE_COND_EN aluc=1110 rf_w=1; without illegal=1 rf_w=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, MIPS opcode/funct encodings and the decoded-control bundle
package alu_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int ALUC_W_DEF = 4;
  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0001;
  localparam logic [3:0] ALUC_AND  = 4'b0011;
  localparam logic [3:0] ALUC_OR   = 4'b0100;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0101;
  localparam logic [3:0] ALUC_SLL  = 4'b1000;
  localparam logic [3:0] ALUC_MOVZ = 4'b1110;
  localparam logic [3:0] ALUC_MOVN = 4'b1100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} bsel_e;
  typedef struct packed {
    logic [3:0]  aluc;
    bsel_e       b_sel;
    logic        rf_w;
    logic [4:0]  rf_dst;
    logic        mem_r;
    logic        mem_w;
    logic        branch;
    logic        illegal;
    logic        uses_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } dec_t;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational MIPS word -> ALU/write-back/memory control decoder
// i_instr: instruction word; o_dec: decoded controls plus rs/rt/imm fields
// MOVE_COND_EN: decode movz/movn, otherwise they are illegal
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);
  logic [5:0] w_op;
  logic [5:0] w_fn;
  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];
  always_comb begin
    o_dec     = '0;
    o_dec.rs  = i_instr[25:21];
    o_dec.rt  = i_instr[20:16];
    o_dec.imm = i_instr[15:0];
    case (w_op)
      OP_RTYPE: begin
        case (w_fn)
          FN_ADD:                  o_dec.aluc = ALUC_ADD;
          FN_ADDU:                 o_dec.aluc = ALUC_ADDU;
          FN_SUB, FN_SUBU, FN_SLT: o_dec.aluc = ALUC_SUB;
          FN_AND:                  o_dec.aluc = ALUC_AND;
          FN_OR:                   o_dec.aluc = ALUC_OR;
          FN_XOR:                  o_dec.aluc = ALUC_XOR;
          FN_NOR:                  o_dec.aluc = ALUC_NOR;
          FN_SLL:                  o_dec.aluc = ALUC_SLL;
`ifdef MOVE_COND_EN
          FN_MOVZ:                 o_dec.aluc = ALUC_MOVZ;
          FN_MOVN:                 o_dec.aluc = ALUC_MOVN;
`endif
          default:                 o_dec.illegal = 1'b1;
        endcase
        // the all-zero word is the canonical nop and must not write $0
        o_dec.rf_w    = !o_dec.illegal && i_instr != '0;
        o_dec.rf_dst  = o_dec.illegal ? 5'd0 : i_instr[15:11];
        o_dec.uses_rt = !o_dec.illegal;
      end
      OP_ADDI, OP_ADDIU: begin
        o_dec.aluc   = w_op == OP_ADDI ? ALUC_ADD : ALUC_ADDU;
        o_dec.b_sel  = B_SEXT;
        o_dec.rf_w   = 1'b1;
        o_dec.rf_dst = i_instr[20:16];
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_dec.aluc   = w_op == OP_ANDI ? ALUC_AND : w_op == OP_ORI ? ALUC_OR : ALUC_XOR;
        o_dec.b_sel  = B_ZEXT;
        o_dec.rf_w   = 1'b1;
        o_dec.rf_dst = i_instr[20:16];
      end
      OP_LW: begin
        o_dec.b_sel  = B_SEXT;
        o_dec.rf_w   = 1'b1;
        o_dec.rf_dst = i_instr[20:16];
        o_dec.mem_r  = 1'b1;
      end
      OP_SW: begin
        o_dec.b_sel   = B_SEXT;
        o_dec.mem_w   = 1'b1;
        o_dec.uses_rt = 1'b1;
      end
      OP_BEQ: begin
        o_dec.aluc    = ALUC_SUB;
        o_dec.branch  = 1'b1;
        o_dec.uses_rt = 1'b1;
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID->EX issue register with valid/ready handshake, load-use bubble and branch flush
// in: clk, rst_n (async low), in_valid, instr, rs_data, rt_data, flush, ex_ready
// out: in_ready, ex_valid, alu_a/b/shamt/aluc, rf_w, rf_dst, mem_r, mem_w, branch, illegal, stall_lu
// MOVE_COND_EN: enables movz/movn decode in alu_ctrl_dec
module id_ex_alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ALUC_W = ALUC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic [XLEN-1:0]   rt_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [4:0]        alu_shamt,
  output logic [ALUC_W-1:0] alu_aluc,
  output logic              rf_w,
  output logic [4:0]        rf_dst,
  output logic              mem_r,
  output logic              mem_w,
  output logic              branch,
  output logic              illegal,
  output logic              stall_lu
);
  dec_t              w_dec;
  logic [XLEN-1:0]   w_b;
  logic              r_ex_valid;
  logic [XLEN-1:0]   r_alu_a;
  logic [XLEN-1:0]   r_alu_b;
  logic [4:0]        r_shamt;
  logic [ALUC_W-1:0] r_aluc;
  logic              r_rf_w;
  logic [4:0]        r_rf_dst;
  logic              r_mem_r;
  logic              r_mem_w;
  logic              r_branch;
  logic              r_illegal;
  alu_ctrl_dec u_dec (
    .i_instr (instr),
    .o_dec   (w_dec)
  );
  assign w_b = w_dec.b_sel == B_SEXT ? {{(XLEN-16){w_dec.imm[15]}}, w_dec.imm} :
               w_dec.b_sel == B_ZEXT ? {{(XLEN-16){1'b0}}, w_dec.imm} : rt_data;
  // loaded value is not available until after EX/MEM, so a dependent word must wait one slot
  assign stall_lu = r_ex_valid && r_mem_r && r_rf_dst != 5'd0 && in_valid && !flush &&
                    (w_dec.rs == r_rf_dst || (w_dec.uses_rt && w_dec.rt == r_rf_dst));
  assign in_ready = rst_n && (!r_ex_valid || ex_ready) && !stall_lu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_shamt    <= '0;
      r_aluc     <= '0;
      r_rf_w     <= 1'b0;
      r_rf_dst   <= '0;
      r_mem_r    <= 1'b0;
      r_mem_w    <= 1'b0;
      r_branch   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_ex_valid <= 1'b1;
      r_alu_a    <= rs_data;
      r_alu_b    <= w_b;
      r_shamt    <= w_dec.imm[10:6];
      r_aluc     <= ALUC_W'(w_dec.aluc);
      r_rf_w     <= w_dec.rf_w;
      r_rf_dst   <= w_dec.rf_dst;
      r_mem_r    <= w_dec.mem_r;
      r_mem_w    <= w_dec.mem_w;
      r_branch   <= w_dec.branch;
      r_illegal  <= w_dec.illegal;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end
  assign ex_valid  = r_ex_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_shamt = r_shamt;
  assign alu_aluc  = r_aluc;
  assign rf_w      = r_rf_w;
  assign rf_dst    = r_rf_dst;
  assign mem_r     = r_mem_r;
  assign mem_w     = r_mem_w;
  assign branch    = r_branch;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: scoreboard bench for the ID->EX issue stage
module tb_id_ex_alu_issue;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, ex_ready;
  logic [31:0] instr, rs_data, rt_data;
  logic        in_ready, ex_valid, rf_w, mem_r, mem_w, branch, illegal, stall_lu;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt, rf_dst;
  logic [3:0]  alu_aluc;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_rdy = 0;
  typedef struct {
    logic [31:0] ins;
    logic [3:0]  aluc;
    logic        b_rt;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        rf_w;
    logic [4:0]  dst;
    logic        mr, mw, br, ill, full, dc;
    logic [31:0] a;
  } exp_t;
  exp_t tbl[$];
  exp_t sb[$];
  id_ex_alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_aluc(alu_aluc), .rf_w(rf_w),
    .rf_dst(rf_dst), .mem_r(mem_r), .mem_w(mem_w), .branch(branch), .illegal(illegal), .stall_lu(stall_lu)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rand_rdy) begin #1; ex_ready = 1'($urandom_range(0, 1)); end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ex_valid && ex_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected got aluc=%b b=%h dst=%0d required no issued word", alu_aluc, alu_b, rf_dst);
      end else begin
        e = sb.pop_front();
        if (alu_aluc !== e.aluc || rf_w !== e.rf_w || mem_r !== e.mr || mem_w !== e.mw || branch !== e.br ||
            illegal !== e.ill || (e.full && (alu_a !== e.a || alu_b !== e.b || alu_shamt !== e.sh)) ||
            (e.dc && rf_dst !== e.dst)) begin
          failures++;
          $display("FAIL issue ins=%h got aluc=%b a=%h b=%h sh=%0d rf_w=%b dst=%0d mr=%b mw=%b br=%b ill=%b required aluc=%b a=%h b=%h sh=%0d rf_w=%b dst=%0d mr=%b mw=%b br=%b ill=%b",
                   e.ins, alu_aluc, alu_a, alu_b, alu_shamt, rf_w, rf_dst, mem_r, mem_w, branch, illegal,
                   e.aluc, e.a, e.b, e.sh, e.rf_w, e.dst, e.mr, e.mw, e.br, e.ill);
        end
      end
    end
  end
  function automatic exp_t mk(input logic [31:0] ins, input logic [3:0] aluc, input logic b_rt,
                              input logic [31:0] b, input logic [4:0] sh, input logic w,
                              input logic [4:0] dst, input logic mr, mw, br, ill, full, dc);
    exp_t e;
    e.ins = ins; e.aluc = aluc; e.b_rt = b_rt; e.b = b; e.sh = sh; e.rf_w = w; e.dst = dst;
    e.mr = mr; e.mw = mw; e.br = br; e.ill = ill; e.full = full; e.dc = dc; e.a = '0;
    return e;
  endfunction
  task automatic init_tbl();
    tbl.push_back(mk(32'h2022FFFF, 4'b0010, 0, 32'hFFFFFFFF, 31, 1, 2,  0, 0, 0, 0, 1, 1)); // 0 addi $2,$1,-1
    tbl.push_back(mk(32'h34038000, 4'b0100, 0, 32'h00008000, 0,  1, 3,  0, 0, 0, 0, 1, 1)); // 1 ori $3,$0,0x8000
    tbl.push_back(mk(32'h000520C0, 4'b1000, 1, 32'h0,        3,  1, 4,  0, 0, 0, 0, 1, 1)); // 2 sll $4,$5,3
    tbl.push_back(mk(32'h012A4022, 4'b0001, 1, 32'h0,        0,  1, 8,  0, 0, 0, 0, 1, 1)); // 3 sub
    tbl.push_back(mk(32'h018D5827, 4'b0101, 1, 32'h0,        0,  1, 11, 0, 0, 0, 0, 1, 1)); // 4 nor
    tbl.push_back(mk(32'h39EEF0F0, 4'b0110, 0, 32'h0000F0F0, 3,  1, 14, 0, 0, 0, 0, 1, 1)); // 5 xori
    tbl.push_back(mk(32'h32B4FFFF, 4'b0011, 0, 32'h0000FFFF, 31, 1, 20, 0, 0, 0, 0, 1, 1)); // 6 andi
    tbl.push_back(mk(32'hAE30FFFC, 4'b0000, 0, 32'hFFFFFFFC, 31, 0, 0,  0, 1, 0, 0, 1, 0)); // 7 sw
    tbl.push_back(mk(32'h12530004, 4'b0001, 1, 32'h0,        0,  0, 0,  0, 0, 1, 0, 1, 0)); // 8 beq
    tbl.push_back(mk(32'h00000000, 4'b1000, 1, 32'h0,        0,  0, 0,  0, 0, 0, 0, 1, 1)); // 9 nop
    tbl.push_back(mk(32'h8C260000, 4'b0000, 0, 32'h0,        0,  1, 6,  1, 0, 0, 0, 1, 1)); // 10 lw $6,0($1)
    tbl.push_back(mk(32'h00C63820, 4'b0010, 1, 32'h0,        0,  1, 7,  0, 0, 0, 0, 1, 1)); // 11 add $7,$6,$6
    tbl.push_back(mk(32'hFC000000, 4'b0000, 0, 32'h0,        0,  0, 0,  0, 0, 0, 1, 0, 0)); // 12 bad opcode
`ifdef MOVE_COND_EN
    tbl.push_back(mk(32'h0043200A, 4'b1110, 1, 32'h0,        0,  1, 4,  0, 0, 0, 0, 1, 1)); // 13 movz
`else
    tbl.push_back(mk(32'h0043200A, 4'b0000, 0, 32'h0,        0,  0, 0,  0, 0, 0, 1, 0, 0)); // 13 movz
`endif
    tbl.push_back(mk(32'h0043082A, 4'b0001, 1, 32'h0,        0,  1, 1,  0, 0, 0, 0, 1, 1)); // 14 slt
    tbl.push_back(mk(32'hAC260000, 4'b0000, 0, 32'h0,        0,  0, 0,  0, 1, 0, 0, 1, 0)); // 15 sw $6,0($1)
    tbl.push_back(mk(32'h20260004, 4'b0010, 0, 32'h4,        0,  1, 6,  0, 0, 0, 0, 1, 1)); // 16 addi $6,$1,4
  endtask
  task automatic send(input exp_t e, input logic [31:0] a, input logic [31:0] b);
    exp_t x = e;
    bit ok = 0;
    x.a = a;
    if (x.b_rt) x.b = b;
    instr = x.ins; rs_data = a; rt_data = b; in_valid = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; sb.push_back(x); end
      @(posedge clk); #1;
    end
    in_valid = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL send_timeout ins=%h in_ready=%b required 1 within 50 cycles", x.ins, in_ready); end
  endtask
  task automatic drain();
    ex_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ex_valid, alu_a, alu_b, alu_shamt, alu_aluc, rf_w, rf_dst, mem_r, mem_w, branch, illegal, stall_lu} !== '0)
      begin failures++; $display("FAIL reset_outputs ex_valid=%b aluc=%b a=%h b=%h required all 0", ex_valid, alu_aluc, alu_a, alu_b); end
    rst_n = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    ex_ready = 0;
    send(tbl[0], 32'h5, 32'h77);
    checks++;
    if (ex_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_hold ex_valid=%b required 1", ex_valid); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, alu_a, alu_b, alu_aluc, rf_w, rf_dst} !== '0)
      begin failures++; $display("FAIL reset_async ex_valid=%b aluc=%b b=%h required all 0", ex_valid, alu_aluc, alu_b); end
    sb.delete();
    @(posedge clk); #1 rst_n = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got %b required 1", in_ready); end
    ex_ready = 1;
  endtask
  task automatic test_decode();
    drain();
    send(tbl[0], 32'h5, $urandom);
    checks++;
    if (ex_valid !== 1'b1 || alu_aluc !== 4'b0010 || alu_b !== 32'hFFFFFFFF || rf_dst !== 5'd2 || rf_w !== 1'b1 || alu_a !== 32'h5)
      begin failures++; $display("FAIL addi_latency ex_valid=%b aluc=%b b=%h dst=%0d rf_w=%b a=%h required 1 0010 ffffffff 2 1 00000005", ex_valid, alu_aluc, alu_b, rf_dst, rf_w, alu_a); end
    for (int i = 1; i < tbl.size(); i++) send(tbl[i], $urandom, $urandom);
    drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL decode_drain pending=%0d required 0", sb.size()); end
  endtask
  task automatic test_load_use();
    exp_t e;
    drain();
    for (int k = 0; k < 2; k++) begin
      send(tbl[10], 32'h100, $urandom);
      e = k == 0 ? tbl[11] : tbl[15];
      rs_data = $urandom; rt_data = $urandom;
      e.a = rs_data;
      if (e.b_rt) e.b = rt_data;
      instr = e.ins; in_valid = 1; #1;
      checks += 2;
      if (stall_lu !== 1'b1) begin failures++; $display("FAIL lu_stall[%0d] got %b required 1", k, stall_lu); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_in_ready[%0d] got %b required 0", k, in_ready); end
      @(posedge clk); #1;
      checks += 3;
      if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble[%0d] ex_valid=%b required 0", k, ex_valid); end
      if (stall_lu !== 1'b0) begin failures++; $display("FAIL lu_stall_clear[%0d] got %b required 0", k, stall_lu); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_resume[%0d] in_ready=%b required 1", k, in_ready); end
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 0;
      checks++;
      if (ex_valid !== 1'b1) begin failures++; $display("FAIL lu_one_bubble[%0d] ex_valid=%b required 1", k, ex_valid); end
      @(posedge clk); #1;
    end
    send(tbl[10], 32'h100, $urandom);
    instr = tbl[16].ins; in_valid = 1; #1;
    checks++;
    if (stall_lu !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL lu_itype_rt stall=%b in_ready=%b required 0 1", stall_lu, in_ready); end
    send(tbl[16], $urandom, $urandom);
    drain();
  endtask
  task automatic test_hold_flush();
    drain();
    ex_ready = 0;
    send(tbl[1], $urandom, $urandom);
    instr = tbl[2].ins; in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ex_valid !== 1'b1 || in_ready !== 1'b0 || alu_b !== 32'h00008000 || alu_aluc !== 4'b0100 || rf_dst !== 5'd3)
        begin failures++; $display("FAIL hold[%0d] ex_valid=%b in_ready=%b b=%h aluc=%b dst=%0d required 1 0 00008000 0100 3", c, ex_valid, in_ready, alu_b, alu_aluc, rf_dst); end
      @(posedge clk); #1;
    end
    flush = 1;
    void'(sb.pop_front());
    @(posedge clk); #1;
    flush = 0;
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_held ex_valid=%b required 0", ex_valid); end
    ex_ready = 1;
    instr = tbl[0].ins; flush = 1; #1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_drop ex_valid=%b required 0", ex_valid); end
    send(tbl[10], 32'h100, $urandom);
    instr = tbl[11].ins; in_valid = 1; flush = 1; #1;
    checks++;
    if (stall_lu !== 1'b0) begin failures++; $display("FAIL flush_stall stall_lu=%b required 0", stall_lu); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_stall_drop ex_valid=%b required 0", ex_valid); end
  endtask
  task automatic test_back_to_back();
    int c0;
    drain();
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(tbl[i], $urandom, $urandom);
    checks++;
    if (cyc - c0 != 4) begin failures++; $display("FAIL back_to_back cycles=%0d required 4", cyc - c0); end
    drain();
  endtask
  task automatic test_backpressure();
    rand_rdy = 1;
    for (int i = 0; i < 24; i++) send(tbl[$urandom_range(0, tbl.size() - 1)], $urandom, $urandom);
    rand_rdy = 0;
    @(posedge clk); #2;
    drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL backpressure_drain pending=%0d required 0", sb.size()); end
  endtask
  initial begin
    rst_n = 0; in_valid = 0; flush = 0; ex_ready = 1;
    instr = '0; rs_data = '0; rt_data = '0;
    init_tbl();
    test_reset();
    test_decode();
    test_load_use();
    test_hold_flush();
    test_back_to_back();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
